divider_256bits_version13: RTL and testbench

DIVIDER_256BITS_VERSION13 -- requirements
Module: divider_256bits_version13

---
 rtl/divider_256bits_version13.sv | 157 +++++++++++++++
 tb/tb_divider_256bits_version13.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_256bits_version13.sv
// -----------------------------------------------------------------------------
// divider_256bits_version13
//
// Unsigned restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit
// divisor, one quotient bit per clock, with a valid/ready handshake on both
// the operand and the result side.
//
// Optional feature (macro DIVIDER_FAST_EXCEPTION_EN):
//   defined   - divide-by-zero and overflow operations skip the iteration phase
//               and present their result one edge after acceptance.
//   undefined - exception operations take the same WIDTH-cycle path as normal
//               operands (default build).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   dividend   [2*WIDTH-1:0] numerator
//   divisor    [WIDTH-1:0]   denominator
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   quotient   [WIDTH-1:0] result quotient (all ones on exception)
//   remainder  [WIDTH-1:0] result remainder (low dividend half on exception)
//   div_zero   divisor was zero
//   overflow   quotient does not fit in WIDTH bits
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
// -----------------------------------------------------------------------------
module divider_256bits_version13 #(
  parameter int WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  // Partial remainder, one bit wider than the divisor so the shifted value
  // never loses its MSB before the compare.
  logic [WIDTH:0]   prem_reg;
  // Low dividend half shifts out of the top while quotient bits shift in at
  // the bottom; after WIDTH steps it holds the full quotient.
  logic [WIDTH-1:0] dq_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             div_zero_reg;
  logic             overflow_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic             accept;
  logic             exc_in_zero;
  logic             exc_in_ovf;
  logic             exc_reg;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH:0]   prem_next;
  logic [WIDTH-1:0] dq_next;

  assign accept      = in_valid && (state_reg == IDLE);
  assign exc_in_zero = (divisor == '0);
  assign exc_in_ovf  = !exc_in_zero && (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign exc_reg     = div_zero_reg || overflow_reg;
  assign last_step   = (cnt_reg == CW'(1));

  // One restoring step: shift in the next dividend bit, subtract on a
  // nonnegative trial difference (sign is the extra top bit of trial).
  assign shifted   = {prem_reg[WIDTH-1:0], dq_reg[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, divisor_reg};
  assign ge        = !trial[WIDTH+1];
  assign prem_next = ge ? trial[WIDTH:0] : shifted;
  assign dq_next   = {dq_reg[WIDTH-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      dq_reg        <= '0;
      divisor_reg   <= '0;
      div_zero_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // High half is below the divisor for every non-exception
            // operand, so it is a valid starting partial remainder.
            prem_reg     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            dq_reg       <= dividend[WIDTH-1:0];
            divisor_reg  <= divisor;
            div_zero_reg <= exc_in_zero;
            overflow_reg <= exc_in_ovf;
            cnt_reg      <= CW'(WIDTH);
`ifdef DIVIDER_FAST_EXCEPTION_EN
            if (exc_in_zero || exc_in_ovf) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend[WIDTH-1:0];
              state_reg     <= DONE;
            end else begin
              state_reg <= RUN;
            end
`else
            state_reg <= RUN;
`endif
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg - CW'(1);
          // Exception operations just count down; dq_reg keeps the low
          // dividend half so it can be returned as the remainder.
          if (!exc_reg) begin
            prem_reg <= prem_next;
            dq_reg   <= dq_next;
          end
          if (last_step) begin
            state_reg     <= DONE;
            quotient_reg  <= exc_reg ? {WIDTH{1'b1}} : dq_next;
            remainder_reg <= exc_reg ? dq_reg : prem_next[WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_divider_256bits_version13.sv
// -----------------------------------------------------------------------------
// tb_divider_256bits_version13
//
// Directed bench for divider_256bits_version13 (WIDTH=256). Each scenario is a
// task with its own inline comparisons. Latency is counted in edges with the
// accepting edge as edge 1, so a normal operation completes at edge WIDTH+1.
// -----------------------------------------------------------------------------
module tb_divider_256bits_version13;

  localparam int W = 256;

`ifdef DIVIDER_FAST_EXCEPTION_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = W + 1;
`endif

  logic           clk;
  logic           rst;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;
  logic           out_valid;
  logic           out_ready;

  int checks;
  int errors;

  divider_256bits_version13 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands at a negedge, lets the next posedge accept them and
  // returns at the first negedge where out_valid is seen (or after a bound).
  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                        output int lat);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL op_timeout got out_valid=%0b exp 1 after %0d edges", out_valid, lat);
    end
    $display("op dividend=%0h divisor=%0h -> q=%0h r=%0h dz=%0b ov=%0b lat=%0d",
             dd, dv, quotient, remainder, div_zero, overflow, lat);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    dividend  = 512'd100;
    divisor   = 256'd7;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_data got q=%0h r=%0h exp 0 0", quotient, remainder);
    end
    checks++;
    if (div_zero !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got dz=%0b ov=%0b ov_valid=%0b in_ready=%0b exp 0 0 0 1",
               div_zero, overflow, out_valid, in_ready);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignore_valid got in_ready=%0b out_valid=%0b exp 1 0", in_ready, out_valid);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(512'd100, 256'd7, lat);
    checks++;
    if (quotient !== 256'd14 || remainder !== 256'd2) begin
      errors++;
      $display("FAIL basic_result got q=%0d r=%0d exp 14 2", quotient, remainder);
    end
    checks++;
    if (div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got dz=%0b ov=%0b exp 0 0", div_zero, overflow);
    end
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL basic_latency got %0d exp %0d", lat, W + 1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_retire got out_valid=%0b in_ready=%0b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_product();
    int lat;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    a = 256'h5829EC10;
    b = 256'h123BBBCF00000000;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    out_ready = 1'b1;
    run_op(p, a, lat);
    checks++;
    if (quotient !== b || remainder !== '0) begin
      errors++;
      $display("FAIL product_result got q=%0h r=%0h exp %0h 0", quotient, remainder, b);
    end
    checks++;
    if (div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL product_flags got dz=%0b ov=%0b exp 0 0", div_zero, overflow);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat;
    out_ready = 1'b1;
    run_op(512'd5, 256'd0, lat);
    checks++;
    if (div_zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL divzero_flags got dz=%0b ov=%0b exp 1 0", div_zero, overflow);
    end
    checks++;
    if (quotient !== {W{1'b1}} || remainder !== 256'd5) begin
      errors++;
      $display("FAIL divzero_result got q=%0h r=%0h exp all-ones 5", quotient, remainder);
    end
    checks++;
    if (lat !== EXC_LAT) begin
      errors++;
      $display("FAIL divzero_latency got %0d exp %0d", lat, EXC_LAT);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat;
    logic [2*W-1:0] dd;
    dd = '0;
    dd[W] = 1'b1;
    out_ready = 1'b1;
    run_op(dd, 256'd1, lat);
    checks++;
    if (overflow !== 1'b1 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flags got ov=%0b dz=%0b exp 1 0", overflow, div_zero);
    end
    checks++;
    if (quotient !== {W{1'b1}} || remainder !== '0) begin
      errors++;
      $display("FAIL overflow_result got q=%0h r=%0h exp all-ones 0", quotient, remainder);
    end
    checks++;
    if (lat !== EXC_LAT) begin
      errors++;
      $display("FAIL overflow_latency got %0d exp %0d", lat, EXC_LAT);
    end
    @(posedge clk);
    @(negedge clk);
    // Flags from the exception must clear on the next acceptance.
    run_op(512'd100, 256'd7, lat);
    checks++;
    if (overflow !== 1'b0 || quotient !== 256'd14) begin
      errors++;
      $display("FAIL overflow_clear got ov=%0b q=%0d exp 0 14", overflow, quotient);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(512'd1000, 256'd10, lat);
    // A second operation is offered throughout the stall and must be ignored.
    dividend = 512'd50;
    divisor  = 256'd3;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 256'd100 ||
          remainder !== 256'd0 || div_zero !== 1'b0 || overflow !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d unstable cycles exp 0 (q=%0d r=%0d out_valid=%0b in_ready=%0b)",
               bad, quotient, remainder, out_valid, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_retire got out_valid=%0b in_ready=%0b exp 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_no_capture got in_ready=%0b exp 1", in_ready);
    end
    $display("backpressure done");
  endtask

  task automatic test_reset_mid_run();
    int lat;
    out_ready = 1'b1;
    dividend  = 512'd1000;
    divisor   = 256'd10;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0 ||
        div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got out_valid=%0b in_ready=%0b q=%0h r=%0h dz=%0b ov=%0b exp 0 1 0 0 0 0",
               out_valid, in_ready, quotient, remainder, div_zero, overflow);
    end
    run_op(512'd100, 256'd7, lat);
    checks++;
    if (quotient !== 256'd14 || remainder !== 256'd2 || lat !== W + 1) begin
      errors++;
      $display("FAIL midrun_rerun got q=%0d r=%0d lat=%0d exp 14 2 %0d", quotient, remainder, lat, W + 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_product();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
